// File: rtl/kernel_rr_scheduler.sv
// Round-robin scheduler sharing one in-order kernel pipeline among NREQ requester streams.
// Issued items are tagged with their requester index so kernel results return to the right lane.
module kernel_rr_scheduler #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TAGD    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_ivalid,
  output logic [NREQ-1:0]         req_iready,
  input  logic [NREQ*STREAMW-1:0] req_data,
  output logic                    k_ivalid,
  input  logic                    k_iready,
  output logic [STREAMW-1:0]      k_idata,
  input  logic                    k_ovalid,
  output logic                    k_oready,
  input  logic [STREAMW-1:0]      k_odata,
  output logic [NREQ-1:0]         rsp_ovalid,
  input  logic [NREQ-1:0]         rsp_oready,
  output logic [STREAMW-1:0]      rsp_data,
  output logic [$clog2(TAGD):0]   inflight,
  output logic                    err_orphan
);

  localparam int unsigned AW = $clog2(TAGD);
  localparam int unsigned CW = AW + 1;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               iss_vld_q, iss_vld_d;
  logic [STREAMW-1:0] iss_data_q, iss_data_d;
  logic [IDW-1:0]     tag_mem_q [TAGD];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               orphan_q, orphan_d;

  logic [STREAMW-1:0] req_word [NREQ];
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic               can_load;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [IDW-1:0]     head_tag;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_word[i] = req_data[i*STREAMW +: STREAMW];
    end
  end

  // Scan from ptr upward with a manual wrap so non-power-of-2 NREQ never yields a tag >= NREQ.
  always_comb begin
    int unsigned slot;
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot = 32'(ptr_q) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!grant_found && req_ivalid[slot[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = slot[IDW-1:0];
      end
    end
  end

  assign can_load   = ~iss_vld_q | k_iready;
  assign fifo_full  = (cnt_q == CW'(TAGD));
  assign fifo_empty = (cnt_q == '0);
  assign head_tag   = tag_mem_q[rd_ptr_q];

  always_comb begin
    req_iready = '0;
    if (rst && grant_found && can_load && !fifo_full) begin
      req_iready[grant_idx] = 1'b1;
    end
  end

  assign push = |(req_iready & req_ivalid);

  always_comb begin
    rsp_ovalid = '0;
    if (k_ovalid && !fifo_empty) begin
      rsp_ovalid[head_tag] = 1'b1;
    end
  end

  assign k_oready = ~fifo_empty & rsp_oready[head_tag];
  assign pop      = k_ovalid & k_oready;
  assign rsp_data = k_odata;

  always_comb begin
    ptr_d      = ptr_q;
    iss_vld_d  = iss_vld_q;
    iss_data_d = iss_data_q;
    if (push) begin
      ptr_d      = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
      iss_vld_d  = 1'b1;
      iss_data_d = req_word[grant_idx];
    end else if (iss_vld_q && k_iready) begin
      iss_vld_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    orphan_d = orphan_q | (k_ovalid & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      orphan_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      iss_vld_q  <= iss_vld_d;
      iss_data_q <= iss_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      orphan_q   <= orphan_d;
    end
  end

  // Tag storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign k_ivalid   = iss_vld_q;
  assign k_idata    = iss_data_q;
  assign inflight   = cnt_q;
  assign err_orphan = orphan_q;

endmodule

// File: tb/tb_kernel_rr_scheduler.sv
// Randomized bench for kernel_rr_scheduler: queue-based reference model, per-lane response
// scoreboard and a small in-order kernel stand-in with fixed latency.
module tb_kernel_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TAGD = 4;
  localparam int W    = 32;
  localparam int LAT  = 3;
  localparam logic [31:0] KMASK = 32'hA5A5_A5A5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_ivalid, req_iready, rsp_ovalid, rsp_oready;
  logic [NREQ*W-1:0] req_data;
  logic            k_ivalid, k_iready, k_ovalid, k_oready, err_orphan;
  logic [W-1:0]    k_idata, k_odata, rsp_data;
  logic [2:0]      inflight;

  kernel_rr_scheduler #(.STREAMW(W), .NREQ(NREQ), .IDW(IDW), .TAGD(TAGD)) dut (
    .clk(clk), .rst(rst),
    .req_ivalid(req_ivalid), .req_iready(req_iready), .req_data(req_data),
    .k_ivalid(k_ivalid), .k_iready(k_iready), .k_idata(k_idata),
    .k_ovalid(k_ovalid), .k_oready(k_oready), .k_odata(k_odata),
    .rsp_ovalid(rsp_ovalid), .rsp_oready(rsp_oready), .rsp_data(rsp_data),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // stimulus state
  logic [31:0] srcq [NREQ][$];
  int  kir_mode = 0;   // 0 ready, 1 stalled, 2 random
  int  ror_mode = 0;   // 0 all ready, 1 none, 2 random
  bit  rand_valid = 0;
  bit  inject = 0;
  int  cyc = 0;
  typedef struct { logic [31:0] d; int rdy; } kitem_t;
  kitem_t kpipe[$];

  // handshakes observed at the negedge, applied by the driver after the next posedge
  bit          hs_acc, hs_kin, hs_kout;
  int          hs_g;
  logic [31:0] hs_kdata;

  // observation records
  int          glog[$];
  int          acc_cnt = 0;
  int          rsp_cnt [NREQ];
  logic [31:0] last_rsp [NREQ];

  // reference model
  int          m_ptr;
  bit          m_iv;
  logic [31:0] m_id;
  int          m_tags[$];
  bit          m_orph;
  logic [31:0] sbq [NREQ][$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      kpipe.delete();
    end else begin
      if (hs_kout && kpipe.size() > 0) void'(kpipe.pop_front());
      if (hs_kin) kpipe.push_back(kitem_t'{hs_kdata ^ KMASK, cyc + LAT - 1});
      if (hs_acc && srcq[hs_g].size() > 0) void'(srcq[hs_g].pop_front());
    end
    for (int i = 0; i < NREQ; i++) begin
      req_ivalid[i] = (srcq[i].size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      req_data[i*W +: W] = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
    end
    k_iready = (kir_mode == 0) ? 1'b1 : (kir_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    rsp_oready = (ror_mode == 0) ? '1 : (ror_mode == 1) ? '0 : 4'($urandom);
    if (inject) begin
      k_ovalid = 1'b1;
      k_odata  = 32'hDEAD_BEEF;
    end else if (kpipe.size() > 0 && kpipe[0].rdy <= cyc) begin
      k_ovalid = 1'b1;
      k_odata  = kpipe[0].d;
    end else begin
      k_ovalid = 1'b0;
      k_odata  = 32'h0;
    end
  end

  // compare process
  always @(negedge clk) begin
    int g, head, ag;
    bit found, e_acc, e_pop, can_load, full, acc;
    logic [NREQ-1:0] e_rdy, e_rov;
    logic e_kor;
    if (!rst) begin
      m_ptr = 0; m_iv = 0; m_id = '0; m_tags.delete(); m_orph = 0;
      for (int i = 0; i < NREQ; i++) sbq[i].delete();
      hs_acc = 0; hs_kin = 0; hs_kout = 0;
      check("rst_req_iready", req_iready, 0);
      check("rst_k_ivalid", k_ivalid, 0);
      check("rst_k_idata", k_idata, 0);
      check("rst_rsp_ovalid", rsp_ovalid, 0);
      check("rst_k_oready", k_oready, 0);
      check("rst_inflight", inflight, 0);
      check("rst_err_orphan", err_orphan, 0);
    end else begin
      found = 0; g = 0;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!found && req_ivalid[idx]) begin found = 1; g = idx; end
      end
      can_load = !m_iv || k_iready;
      full = (m_tags.size() == TAGD);
      e_rdy = '0;
      if (found && can_load && !full) e_rdy[g] = 1'b1;
      e_rov = '0; e_kor = 0; head = 0;
      if (m_tags.size() > 0) begin
        head = m_tags[0];
        e_rov[head] = k_ovalid;
        e_kor = rsp_oready[head];
      end
      check("req_iready", req_iready, e_rdy);
      check("k_ivalid", k_ivalid, m_iv);
      check("k_idata", k_idata, m_id);
      check("rsp_ovalid", rsp_ovalid, e_rov);
      check("k_oready", k_oready, e_kor);
      check("rsp_data", rsp_data, k_odata);
      check("inflight", inflight, m_tags.size());
      check("err_orphan", err_orphan, m_orph);

      for (int i = 0; i < NREQ; i++) begin
        if (rsp_ovalid[i] && rsp_oready[i]) begin
          if (sbq[i].size() == 0) fail_now("rsp_unexpected");
          else check("rsp_route", rsp_data, sbq[i].pop_front());
          rsp_cnt[i]++;
          last_rsp[i] = rsp_data;
        end
      end

      acc = 0; ag = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ivalid[i] && req_iready[i]) begin acc = 1; ag = i; end
      end
      if (acc) begin
        sbq[ag].push_back(req_data[ag*W +: W] ^ KMASK);
        glog.push_back(ag);
        acc_cnt++;
      end
      hs_acc = acc; hs_g = ag;
      hs_kin = k_ivalid && k_iready; hs_kdata = k_idata;
      hs_kout = k_ovalid && k_oready;

      e_acc = found && e_rdy[g];
      e_pop = k_ovalid && (m_tags.size() > 0) && rsp_oready[head];
      if (k_ovalid && m_tags.size() == 0) m_orph = 1;
      if (e_pop) void'(m_tags.pop_front());
      if (e_acc) begin
        m_tags.push_back(g);
        m_iv = 1; m_id = req_data[g*W +: W];
        m_ptr = (g + 1) % NREQ;
      end else if (m_iv && k_iready) begin
        m_iv = 0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
             srcq[3].size() == 0 && kpipe.size() == 0 && inflight == 0 && !k_ivalid)) begin
      @(posedge clk); #2;
      n++;
      if (n > budget) begin fail_now("idle_timeout"); break; end
    end
  endtask

  task automatic clear_obs();
    glog.delete(); acc_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin rsp_cnt[i] = 0; last_rsp[i] = '0; end
  endtask

  initial begin
    int exp_g[8];
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst = 0; req_ivalid = '0; req_data = '0; k_iready = 1; k_ovalid = 0; k_odata = '0;
    rsp_oready = '1;
    clear_obs();
    #2;
    check("lit_rst_req_iready", req_iready, 0);
    check("lit_rst_inflight", inflight, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1;

    // all requesters valid, grants rotate 0,1,2,3
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 12; n++) srcq[i].push_back(32'h100 * i + n);
    wait_idle(600);
    for (int i = 0; i < 8; i++)
      check("lit_grant_seq", (i < glog.size()) ? glog[i] : 99, exp_g[i]);
    for (int i = 0; i < NREQ; i++) check("lit_rsp_cnt_all", rsp_cnt[i], 12);

    // only requester 2
    clear_obs(); ror_mode = 2;
    for (int n = 0; n < 8; n++) srcq[2].push_back(32'h20 + n);
    wait_idle(600);
    check("lit_req2_rsp_cnt", rsp_cnt[2], 8);
    check("lit_req2_other_cnt", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[3], 0);
    check("lit_req2_last", last_rsp[2], 32'hA5A5_A582);
    ror_mode = 0;

    // kernel input stalled: exactly one word parked in the issue register
    clear_obs(); kir_mode = 1;
    srcq[0].push_back(32'h300); srcq[0].push_back(32'h301);
    srcq[1].push_back(32'h310); srcq[1].push_back(32'h311);
    repeat (3) @(posedge clk); #2;
    check("lit_stall_idata_a", k_idata, 32'h300);
    repeat (5) @(posedge clk); #2;
    check("lit_stall_idata_b", k_idata, 32'h300);
    check("lit_stall_ivalid", k_ivalid, 1);
    check("lit_stall_inflight", inflight, 1);
    check("lit_stall_iready", req_iready, 0);
    kir_mode = 0;
    wait_idle(600);

    // response path blocked: tag FIFO fills to TAGD and stops accepting
    clear_obs(); ror_mode = 1;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 6; n++) srcq[i].push_back(32'h4000 + 32'h100 * i + n);
    repeat (20) @(posedge clk); #2;
    check("lit_full_accepts", acc_cnt, TAGD);
    check("lit_full_inflight", inflight, TAGD);
    check("lit_full_iready", req_iready, 0);
    ror_mode = 0;
    wait_idle(600);
    check("lit_full_drained", acc_cnt, 24);

    // randomized traffic
    rand_valid = 1; kir_mode = 2; ror_mode = 2;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 40; n++) srcq[i].push_back($urandom);
    wait_idle(3000);
    rand_valid = 0; kir_mode = 0; ror_mode = 0;

    // orphan output
    @(posedge clk); #3 inject = 1;
    @(posedge clk); #3 inject = 0;
    @(posedge clk); #2;
    check("lit_orphan_set", err_orphan, 1);
    repeat (5) @(posedge clk); #2;
    check("lit_orphan_sticky", err_orphan, 1);

    // reset in the middle of a burst
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 10; n++) srcq[i].push_back(32'h7000 + 32'h100 * i + n);
    repeat (6) @(posedge clk);
    #2 rst = 0;
    #1;
    check("lit_mid_rst_ivalid", k_ivalid, 0);
    check("lit_mid_rst_iready", req_iready, 0);
    check("lit_mid_rst_inflight", inflight, 0);
    check("lit_mid_rst_orphan", err_orphan, 0);
    check("lit_mid_rst_rov", rsp_ovalid, 0);
    repeat (2) @(posedge clk);
    clear_obs();
    #3 rst = 1;
    wait_idle(600);
    check("lit_post_rst_grant", (glog.size() > 0) ? glog[0] : 99, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kernel_rr_scheduler.md
Name: kernel_rr_scheduler

Overview:
- Shares one kernel pipeline instance among NREQ requester streams using round-robin arbitration.
- Each accepted item is tagged with its requester index in an in-order tag FIFO. The kernel's result is routed back to that requester's response channel.
- Sits between the per-lane stream sources/sinks and a single kernelTop_* instance, all on the valid/ready handshake.

Parameters:
- STREAMW, 32, data width of every stream word.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, tag width; must satisfy 2^IDW >= NREQ.
- TAGD, 16, tag FIFO depth (power of 2). It must be >= kernel pipeline depth + 1 for full throughput.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req_ivalid  in  NREQ  per-requester input valid.
- req_iready  out  NREQ  per-requester input ready; at most one bit high per cycle.
- req_data  in  NREQ*STREAMW  packed requester data; requester i occupies bits [i*STREAMW +: STREAMW].
- k_ivalid  out  1  valid to kernel input.
- k_iready  in  1  kernel input ready.
- k_idata  out  STREAMW  data to kernel.
- k_ovalid  in  1  kernel output valid.
- k_oready  out  1  ready to kernel output.
- k_odata  in  STREAMW  kernel result.
- rsp_ovalid  out  NREQ  one-hot response valid.
- rsp_oready  in  NREQ  per-requester response ready.
- rsp_data  out  STREAMW  shared response data (= k_odata).
- inflight  out  $clog2(TAGD)+1  tag FIFO occupancy.
- err_orphan  out  1  sticky flag: kernel produced output with no tag outstanding.

Behaviour:
- Reset (rst=0, async): grant pointer=0; issue register empty (k_ivalid=0, k_idata=0); tag FIFO empty (inflight=0); err_orphan=0. Combinational outputs follow: req_iready=0, rsp_ovalid=0, k_oready=0.
- Issue register:
  - Holds exactly one word. It can_load when empty, or when k_ivalid & k_iready this cycle.
  - k_ivalid/k_idata are driven directly from the register.
  - Data is held stable while k_ivalid=1 and k_iready=0.
- Arbitration (combinational):
  - Scan requesters starting at ptr, wrapping modulo NREQ; g = first i with req_ivalid[i].
  - req_iready[g] = can_load & ~fifo_full; all other bits 0.
  - accept = req_ivalid[g] & req_iready[g].
- On accept (registered):
  - The issue register loads req_data[g].
  - Tag g is pushed to the tag FIFO.
  - ptr <= (g+1) mod NREQ.
- With no accept, ptr holds. A requester that drops valid loses its turn without penalty.
- Latency: requester accept at cycle T gives k_ivalid=1 at T+1. Sustained throughput is 1 item/cycle when the kernel is always ready and the FIFO is not full.
- Full rule: fifo_full blocks push even if a pop occurs in the same cycle. The FIFO never exceeds TAGD entries.
- Return path (combinational):
  - head = FIFO head tag.
  - rsp_ovalid[head] = k_ovalid & ~fifo_empty; other bits 0.
  - rsp_data = k_odata.
  - k_oready = ~fifo_empty & rsp_oready[head].
  - Pop when k_ovalid & k_oready.
- Simultaneous push and pop (FIFO not full): both occur and inflight is unchanged.
- Order: results are assumed in issue order (kernel is in-order). The FIFO head always matches the oldest issued item.
- Orphan: k_ovalid=1 while fifo_empty sets err_orphan=1, held until reset. k_oready stays 0 in that case.
- inflight counts FIFO entries: +1 per push, -1 per pop. This includes the item sitting in the issue register.
- NREQ not a power of 2: ptr wraps from NREQ-1 to 0. Tag values >= NREQ never occur.
- Reset mid-operation clears all state immediately. Items in the kernel are then untracked, and their later outputs raise err_orphan. Upstream must flush the kernel on the same reset.

Test Plan:
- All 4 requesters valid continuously; kernel is a 3-stage ready=1 passthrough; req i sends 0x100*i+n -> grants 0,1,2,3,0,... every cycle. Each rsp_data reaches the matching rsp_ovalid bit in order; inflight settles at 4.
- Only req2 valid, 8 words 0x20..0x27 -> granted every cycle; ptr stays cycling back to 2; 8 responses on rsp_ovalid=4'b0100.
- Kernel k_iready=0 for 5 cycles with req0 and req1 valid -> one word held in the issue register with k_idata stable; req_iready=0; no extra tags pushed (inflight=1).
- TAGD=4, kernel output stalled (rsp_oready=0) -> exactly 4 accepts, then req_iready=0. Release rsp_oready -> responses drain in order and accepts resume.
- rsp_oready[head]=0 while another requester is ready -> k_oready=0 (head-of-line); no reorder.
- Inject k_ovalid=1 with inflight=0 -> err_orphan=1 next cycle and stays 1 until rst=0. Assert rst mid-burst -> all outputs 0 asynchronously, ptr=0.
